// File: rtl/dcw_bringup_seq.sv
// dcw_bringup_seq
//   Bring-up sequencer for the data channel wrapper. Holds the channel in reset
//   for RST_CYCLES and then applies the captured initial width while waiting for
//   link lock. On lock it switches to the captured run width. Busy, done and
//   error status go to the BERT control logic.
//
//   Optional feature macro: DCW_SEQ_RETRY_EN
//     When it is defined, a lock timeout restarts the reset phase up to MAX_RETRY
//     times before the sequencer gives up in ERR.
//     When it is undefined, any timeout goes straight to ERR, and retry_cnt is tied to 0.
//
//   Every output is registered and decoded from the next state. A state's outputs
//   are therefore already valid on the clock edge that enters that state.
module dcw_bringup_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CNT_W        = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       lock,
    input  logic [2:0] width_init,
    input  logic [2:0] width_run,
    output logic [2:0] ctrl_sig,
    output logic [2:0] val,
    output logic [2:0] val1,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_ERR
    } state_t;

    // Wrapper command encodings
    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_RST      = 3'd1;
    localparam logic [2:0] CMD_RUN_INIT = 3'd2;
    localparam logic [2:0] CMD_RUN_RUN  = 3'd3;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       val_next, val1_next;
    logic [2:0]       ctrl_next;
    logic             busy_next, done_next, error_next;
    logic             timeout;

`ifdef DCW_SEQ_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    logic [1:0] retry_reg, retry_next;
`endif

    // A timeout is the last allowed WAIT_LOCK cycle still passing without lock
    assign timeout = (cnt_reg == LOCK_LAST);

    // Next-state logic, width capture and retry bookkeeping
    always_comb begin
        state_next = state_reg;
        val_next   = val;
        val1_next  = val1;
`ifdef DCW_SEQ_RETRY_EN
        retry_next = retry_reg;
`endif
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        val_next   = width_init;
                        val1_next  = width_run;
                        state_next = ST_RST;
`ifdef DCW_SEQ_RETRY_EN
                        retry_next = 2'd0;
`endif
                    end
                end
                ST_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a timeout that lands on the same cycle
                    if (lock) begin
                        state_next = ST_RUN;
                    end else if (timeout) begin
`ifdef DCW_SEQ_RETRY_EN
                        if (retry_reg < RETRY_LIMIT) begin
                            state_next = ST_RST;
                            retry_next = retry_reg + 2'd1;
                        end else begin
                            state_next = ST_ERR;
                        end
`else
                        state_next = ST_ERR;
`endif
                    end
                end
                ST_RUN: begin
                    if (!lock) begin
                        state_next = ST_ERR;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Shared cycle counter: cleared on a state change or an abort, and it saturates at full scale
    always_comb begin
        cnt_next = cnt_reg;
        if (abort || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Output decode from the next state, so the outputs register together with the state
    always_comb begin
        ctrl_next  = CMD_NONE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        error_next = 1'b0;
        unique case (state_next)
            ST_RST: begin
                ctrl_next = CMD_RST;
                busy_next = 1'b1;
            end
            ST_WAIT_LOCK: begin
                ctrl_next = CMD_RUN_INIT;
                busy_next = 1'b1;
            end
            ST_RUN: begin
                ctrl_next = CMD_RUN_RUN;
                done_next = 1'b1;
            end
            ST_ERR: begin
                ctrl_next  = CMD_RST;
                error_next = 1'b1;
            end
            default: ctrl_next = CMD_NONE;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            val       <= 3'd0;
            val1      <= 3'd0;
            ctrl_sig  <= CMD_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            val       <= val_next;
            val1      <= val1_next;
            ctrl_sig  <= ctrl_next;
            busy      <= busy_next;
            done      <= done_next;
            error     <= error_next;
        end
    end

`ifdef DCW_SEQ_RETRY_EN
    // Retry counter: cleared on an accepted start and held in ERR for inspection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_reg <= 2'd0;
        end else begin
            retry_reg <= retry_next;
        end
    end

    assign retry_cnt = retry_reg;
`else
    assign retry_cnt = 2'd0;
`endif

endmodule

// File: tb/tb_dcw_bringup_seq.sv
// tb_dcw_bringup_seq
//   Randomized scenario bench for dcw_bringup_seq. Expected outputs come from a
//   timeline model: the cycle index since start and the lock cycle k map to a phase.
//   Build it with DCW_SEQ_RETRY_EN defined to check the retry variant.
module tb_dcw_bringup_seq;

    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int MAX_RETRY    = 3;
`ifdef DCW_SEQ_RETRY_EN
    localparam int PASSES = MAX_RETRY + 1;
`else
    localparam int PASSES = 1;
`endif
    localparam int PASS_LEN = RST_CYCLES + LOCK_TIMEOUT;

    // Phase codes for the reference timeline
    localparam int PH_RST = 0;
    localparam int PH_WL  = 1;
    localparam int PH_RUN = 2;
    localparam int PH_ERR = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, abort, lock;
    logic [2:0] width_init, width_run;
    logic [2:0] ctrl_sig, val, val1;
    logic       busy, done, error;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    dcw_bringup_seq #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .CNT_W       (16),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .lock      (lock),
        .width_init(width_init),
        .width_run (width_run),
        .ctrl_sig  (ctrl_sig),
        .val       (val),
        .val1      (val1),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .retry_cnt (retry_cnt)
    );

    always #5 clock = ~clock;

    // Advance one clock and land on the falling edge, where outputs are sampled and inputs driven
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Phase at sample t after start. k > 0 means lock rises on the k-th WAIT_LOCK cycle, and k == 0 means never
    function automatic int ref_phase(input int t, input int k);
        if (k > 0) begin
            if (t < RST_CYCLES) return PH_RST;
            if (t < RST_CYCLES + k) return PH_WL;
            return PH_RUN;
        end
        if (t >= PASSES * PASS_LEN) return PH_ERR;
        return ((t % PASS_LEN) < RST_CYCLES) ? PH_RST : PH_WL;
    endfunction

    function automatic logic [2:0] ref_ctrl(input int ph);
        case (ph)
            PH_RST:  return 3'd1;
            PH_WL:   return 3'd2;
            PH_RUN:  return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] ref_retry(input int t);
        int p;
        p = t / PASS_LEN;
        if (p > PASSES - 1) p = PASSES - 1;
        return 2'(p);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; start = 0; abort = 0; lock = 0; width_init = 0; width_run = 0;
        #1;
        checks++;
        if ({ctrl_sig, val, val1, busy, done, error, retry_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", {ctrl_sig, val, val1, busy, done, error, retry_cnt});
        end
        step(); step();
        reset_n = 1'b1;
        step(); step();
        checks++;
        if (ctrl_sig !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ctrl=%0d busy=%0b, want 0/0", ctrl_sig, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_bringup(input int k, input logic [2:0] wi, input logic [2:0] wr);
        logic [2:0] ec;
        int ph;
        width_init = wi; width_run = wr; lock = 0; start = 1;
        step();
        start = 0;
        for (int t = 0; t < RST_CYCLES + k + 3; t++) begin
            ph = ref_phase(t, k);
            ec = ref_ctrl(ph);
            checks++;
            if (ctrl_sig !== ec || busy !== (ph < PH_RUN) || done !== (ph == PH_RUN)) begin
                errors++;
                $display("FAIL bringup_t%0d_k%0d: ctrl=%0d busy=%0b done=%0b, want ctrl=%0d phase=%0d",
                         t, k, ctrl_sig, busy, done, ec, ph);
            end
            if (t == RST_CYCLES + k - 1) lock = 1;
            step();
        end
        checks++;
        if (val !== wi || val1 !== wr) begin
            errors++;
            $display("FAIL bringup_widths: val=%0d val1=%0d, want %0d/%0d", val, val1, wi, wr);
        end
        abort = 1;
        step();
        abort = 0; lock = 0;
        checks++;
        if (ctrl_sig !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL bringup_abort_run: ctrl=%0d done=%0b, want 0/0", ctrl_sig, done);
        end
        $display("test_bringup k=%0d wi=%0d wr=%0d", k, wi, wr);
    endtask

    task automatic test_timeout();
        int ph;
        lock = 0;
        width_init = 3'($urandom_range(0, 7)); width_run = 3'($urandom_range(0, 7));
        start = 1;
        step();
        start = 0;
        for (int t = 0; t < PASSES * PASS_LEN + 3; t++) begin
            ph = ref_phase(t, 0);
            checks++;
            if (ctrl_sig !== ref_ctrl(ph) || busy !== (ph < PH_RUN) || error !== (ph == PH_ERR)
                || retry_cnt !== ref_retry(t)) begin
                errors++;
                $display("FAIL timeout_t%0d: ctrl=%0d busy=%0b error=%0b retry=%0d, want ctrl=%0d phase=%0d retry=%0d",
                         t, ctrl_sig, busy, error, retry_cnt, ref_ctrl(ph), ph, ref_retry(t));
            end
            step();
        end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || ctrl_sig !== 3'd1 || retry_cnt !== 2'(PASSES - 1)) begin
            errors++;
            $display("FAIL timeout_final: error=%0b busy=%0b ctrl=%0d retry=%0d, want 1/0/1/%0d",
                     error, busy, ctrl_sig, retry_cnt, PASSES - 1);
        end
        $display("test_timeout passes=%0d", PASSES);
    endtask

    task automatic test_lock_loss(input int k, input int hold);
        abort = 1; step(); abort = 0;
        width_init = 3'($urandom_range(0, 7)); width_run = 3'($urandom_range(0, 7));
        start = 1; step(); start = 0;
        for (int t = 0; t < RST_CYCLES + k; t++) begin
            if (t == RST_CYCLES + k - 1) lock = 1;
            step();
        end
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (done !== 1'b1 || ctrl_sig !== 3'd3) begin
                errors++;
                $display("FAIL lockloss_run_h%0d: done=%0b ctrl=%0d, want 1/3", h, done, ctrl_sig);
            end
            step();
        end
        lock = 0; step(); lock = 1;
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || ctrl_sig !== 3'd1) begin
            errors++;
            $display("FAIL lockloss_err: error=%0b done=%0b ctrl=%0d, want 1/0/1", error, done, ctrl_sig);
        end
        width_init = 3'd4; start = 1; step(); start = 0; lock = 0;
        checks++;
        if (ctrl_sig !== 3'd1 || val !== 3'd4 || busy !== 1'b1 || error !== 1'b0 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL lockloss_restart: ctrl=%0d val=%0d busy=%0b error=%0b retry=%0d, want 1/4/1/0/0",
                     ctrl_sig, val, busy, error, retry_cnt);
        end
        abort = 1; step(); abort = 0;
        $display("test_lock_loss k=%0d hold=%0d", k, hold);
    endtask

    task automatic test_abort(input int at);
        lock = 0; start = 1; step(); start = 0;
        for (int t = 0; t < at; t++) step();
        abort = 1; step(); abort = 0;
        checks++;
        if (ctrl_sig !== 3'd0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL abort_at%0d: ctrl=%0d busy=%0b error=%0b, want 0/0/0", at, ctrl_sig, busy, error);
        end
        start = 1; abort = 1; step(); start = 0; abort = 0;
        step();
        checks++;
        if (ctrl_sig !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle: ctrl=%0d busy=%0b, want 0/0", ctrl_sig, busy);
        end
        $display("test_abort at=%0d", at);
    endtask

    task automatic test_start_ignored(input int k);
        logic [2:0] wi, wr;
        int pulse;
        wi = 3'($urandom_range(0, 7)); wr = 3'($urandom_range(0, 7));
        pulse = RST_CYCLES + 2;
        width_init = wi; width_run = wr; lock = 0; start = 1; step(); start = 0;
        for (int t = 0; t < RST_CYCLES + k + 2; t++) begin
            if (t == pulse) begin
                checks++;
                if (ctrl_sig !== 3'd2 || val !== wi || val1 !== wr) begin
                    errors++;
                    $display("FAIL ignore_start_wl: ctrl=%0d val=%0d val1=%0d, want 2/%0d/%0d", ctrl_sig, val, val1, wi, wr);
                end
            end
            if (t == RST_CYCLES + k) begin
                checks++;
                if (ctrl_sig !== 3'd3 || val !== wi || val1 !== wr) begin
                    errors++;
                    $display("FAIL ignore_start_run: ctrl=%0d val=%0d val1=%0d, want 3/%0d/%0d", ctrl_sig, val, val1, wi, wr);
                end
            end
            start = (t == pulse);
            if (t == pulse) begin
                width_init = ~wi; width_run = ~wr;
            end
            if (t == RST_CYCLES + k - 1) lock = 1;
            step();
        end
        start = 0;
        abort = 1; step(); abort = 0; lock = 0;
        $display("test_start_ignored k=%0d", k);
    endtask

    task automatic test_async_reset();
        lock = 0; width_init = 3'd6; width_run = 3'd7; start = 1; step(); start = 0;
        for (int t = 0; t < RST_CYCLES + 3; t++) step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_sig, val, val1, busy, done, error, retry_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, want 0", {ctrl_sig, val, val1, busy, done, error, retry_cnt});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int t = 0; t < 4; t++) step();
        checks++;
        if (ctrl_sig !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: ctrl=%0d busy=%0b, want 0/0", ctrl_sig, busy);
        end
        start = 1; step(); start = 0;
        checks++;
        if (ctrl_sig !== 3'd1 || val !== 3'd6) begin
            errors++;
            $display("FAIL async_reset_restart: ctrl=%0d val=%0d, want 1/6", ctrl_sig, val);
        end
        abort = 1; step(); abort = 0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_bringup(10, 3'd2, 3'd5);
        test_bringup(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        test_bringup(LOCK_TIMEOUT, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 4; i++) begin
            test_bringup(int'($urandom_range(1, 200)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        test_timeout();
        test_lock_loss(int'($urandom_range(1, 50)), int'($urandom_range(1, 20)));
        test_abort(4);
        test_abort(int'($urandom_range(0, RST_CYCLES + 40)));
        test_start_ignored(int'($urandom_range(10, 60)));
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
